inst_fetch: RTL

Instruction fetch unit for the RV32I core. It generates sequential word-aligned PCs and issues one request at a time to instruction memory. Returned words go into a 2-entry buffer that presents `inst`/`inst_pc` to the decode stage over a valid/ready handshake. It drives the same 32-bit `INST` word that decode consumes and accepts PC redirects from branch/jump resolution.

---
 rtl/rv32i_pkg.sv | 12 +
 rtl/inst_fetch_buf.sv | 52 +++++
 rtl/inst_fetch.sv | 127 ++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the instruction fetch unit.
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HALT = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/inst_fetch_buf.sv
// Small synchronous FIFO holding {instruction, pc} pairs between fetch and decode.
module inst_fetch_buf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rest,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A push into a full buffer is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// RV32I instruction fetch: one outstanding imem request, 2-entry output buffer, PC redirect.
// Optional misaligned-redirect trap enabled by INST_FETCH_ALIGN_CHECK_EN.
module inst_fetch
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rest,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_err
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(BUF_DEPTH);

  fetch_state_t      state_q;
  logic [XLEN-1:0]   pc_q, req_pc_q, redir_pc;
  logic              drop_q, fetch_err_q, misalign;
  logic              push, pop, buf_empty, buf_full, slot_free;
  logic [AW:0]       count, count_d;
  logic [2*XLEN-1:0] buf_rdata;

  assign redir_pc = redirect_pc & 32'hFFFF_FFFC;
`ifdef INST_FETCH_ALIGN_CHECK_EN
  assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign imem_req   = (state_q == REQ);
  assign imem_addr  = pc_q;
  assign inst_valid = !buf_empty;
  assign inst       = buf_rdata[2*XLEN-1:XLEN];
  assign inst_pc    = buf_rdata[XLEN-1:0];
  assign fetch_err  = fetch_err_q;

  assign pop       = inst_valid && inst_ready;
  assign push      = (state_q == WAIT) && imem_rvalid && !drop_q && !buf_full;
  // Occupancy after this cycle's push/pop decides whether another request fits.
  assign count_d   = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign slot_free = (count_d < DEPTH_C);

  inst_fetch_buf #(
    .WIDTH (2*XLEN),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rest  (rest),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata ({imem_rdata, req_pc_q}),
    .rdata (buf_rdata),
    .full  (buf_full),
    .empty (buf_empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      drop_q      <= 1'b0;
      fetch_err_q <= 1'b0;
    end else if (redirect_valid && state_q != HALT) begin
      pc_q <= redir_pc;
      if (misalign) begin
        state_q     <= HALT;
        drop_q      <= 1'b0;
        fetch_err_q <= 1'b1;
      end else begin
        case (state_q)
          REQ: begin
            if (imem_ack) begin
              req_pc_q <= pc_q;
              drop_q   <= 1'b1;
              state_q  <= WAIT;
            end else begin
              state_q <= REQ;
            end
          end
          // A response arriving with the redirect is discarded by the flush, so nothing stays outstanding.
          WAIT: begin
            if (imem_rvalid) begin
              drop_q  <= 1'b0;
              state_q <= REQ;
            end else begin
              drop_q  <= 1'b1;
              state_q <= WAIT;
            end
          end
          default: state_q <= REQ;
        endcase
      end
    end else begin
      case (state_q)
        IDLE: if (slot_free) state_q <= REQ;
        REQ: begin
          if (imem_ack) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + 32'd4;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            drop_q  <= 1'b0;
            state_q <= (drop_q || slot_free) ? REQ : IDLE;
          end
        end
        default: state_q <= HALT;
      endcase
    end
  end
endmodule
